// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply, restoring divide.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU/REM/REMU complete at once flagged illegal_op.
module ex_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_enable,
  output logic        stall_req,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_rd_enable,
  output logic        illegal_op
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MDU_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_reg;
  logic [5:0]  cnt_reg;
  logic [2:0]  op_reg;
  logic [4:0]  rd_reg;
  logic        rd_en_reg;
  logic [63:0] acc_reg;
  logic [31:0] opnd_reg;
  logic        neg_reg;
  logic [31:0] out_data_reg;
  logic [4:0]  out_rd_reg;
  logic        out_rd_en_reg;

  // Operand signedness and magnitudes, taken straight from the ID/EX operands at the accept edge.
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (in_op[2]) begin
      a_signed = ~in_op[0];
      b_signed = ~in_op[0];
    end else begin
      a_signed = (in_op[1:0] == 2'b01) || (in_op[1:0] == 2'b10);
      b_signed = (in_op[1:0] == 2'b01);
    end
  end

  assign a_neg = a_signed & in_rs1[31];
  assign b_neg = b_signed & in_rs2[31];
  assign a_mag = a_neg ? (~in_rs1 + 32'd1) : in_rs1;
  assign b_mag = b_neg ? (~in_rs2 + 32'd1) : in_rs2;

  // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
  logic [32:0] mul_sum;
  logic [63:0] mul_step, mul_prod;
  logic [31:0] mul_res;

  assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
  assign mul_step = {mul_sum, acc_reg[31:1]};
  assign mul_prod = neg_reg ? (~acc_reg + 64'd1) : acc_reg;
  assign mul_res  = (op_reg == 3'b000) ? mul_prod[31:0] : mul_prod[63:32];

`ifdef MDU_DIV_EN
  // Divide: acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  logic        neg_rem_reg, dz_reg, ovf_reg;
  logic [31:0] rs1_reg;
  logic [32:0] div_trial;
  logic [63:0] div_step;
  logic [31:0] quo_fix, rem_fix, div_res, fast_res;

  assign div_trial = acc_reg[63:31] - {1'b0, opnd_reg};
  assign div_step  = div_trial[32] ? {acc_reg[62:0], 1'b0}
                                   : {div_trial[31:0], acc_reg[30:0], 1'b1};
  assign quo_fix   = neg_reg     ? (~acc_reg[31:0] + 32'd1)  : acc_reg[31:0];
  assign rem_fix   = neg_rem_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
  assign div_res   = op_reg[1] ? rem_fix : quo_fix;
  assign fast_res  = dz_reg ? (op_reg[1] ? rs1_reg : 32'hFFFF_FFFF)
                            : (op_reg[1] ? 32'd0   : 32'h8000_0000);

  assign stall_req  = (state_reg == S_IDLE && in_valid) || state_reg == S_MUL || state_reg == S_DIV;
  assign illegal_op = 1'b0;
`else
  logic illegal_reg;

  assign stall_req  = (state_reg == S_IDLE && in_valid) || state_reg == S_MUL;
  assign illegal_op = out_valid & illegal_reg;
`endif

  // A flush in the DONE cycle must kill the result strobe without waiting for an edge.
  assign out_valid     = (state_reg == S_DONE) && !flush;
  assign out_data      = out_data_reg;
  assign out_rd        = out_rd_reg;
  assign out_rd_enable = out_rd_en_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      out_data_reg  <= '0;
      out_rd_reg    <= '0;
      out_rd_en_reg <= 1'b0;
`ifndef MDU_DIV_EN
      illegal_reg   <= 1'b0;
`endif
    end else if (flush) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            op_reg    <= in_op;
            rd_reg    <= in_rd;
            rd_en_reg <= in_rd_enable;
            cnt_reg   <= '0;
            neg_reg   <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
            rs1_reg     <= in_rs1;
            neg_rem_reg <= a_neg;
            dz_reg      <= (in_rs2 == 32'd0);
            ovf_reg     <= ~in_op[0] && (in_rs1 == 32'h8000_0000) && (in_rs2 == 32'hFFFF_FFFF);
            if (in_op[2]) begin
              acc_reg   <= {32'd0, a_mag};
              opnd_reg  <= b_mag;
              state_reg <= S_DIV;
            end else begin
              acc_reg   <= {32'd0, b_mag};
              opnd_reg  <= a_mag;
              state_reg <= S_MUL;
            end
`else
            acc_reg   <= {32'd0, b_mag};
            opnd_reg  <= a_mag;
            state_reg <= S_MUL;
`endif
          end
        end
        S_MUL: begin
`ifndef MDU_DIV_EN
          // Unsupported divide ops ride through MUL for one cycle so they match the divider fast-path timing.
          if (op_reg[2]) begin
            out_data_reg  <= '0;
            out_rd_reg    <= rd_reg;
            out_rd_en_reg <= 1'b0;
            illegal_reg   <= 1'b1;
            state_reg     <= S_DONE;
          end else
`endif
          if (cnt_reg == 6'd32) begin
            out_data_reg  <= mul_res;
            out_rd_reg    <= rd_reg;
            out_rd_en_reg <= rd_en_reg;
`ifndef MDU_DIV_EN
            illegal_reg   <= 1'b0;
`endif
            state_reg     <= S_DONE;
          end else begin
            acc_reg <= mul_step;
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
`ifdef MDU_DIV_EN
        S_DIV: begin
          if (dz_reg || ovf_reg) begin
            out_data_reg  <= fast_res;
            out_rd_reg    <= rd_reg;
            out_rd_en_reg <= rd_en_reg;
            state_reg     <= S_DONE;
          end else if (cnt_reg == 6'd32) begin
            out_data_reg  <= div_res;
            out_rd_reg    <= rd_reg;
            out_rd_en_reg <= rd_en_reg;
            state_reg     <= S_DONE;
          end else begin
            acc_reg <= div_step;
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
`endif
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
